// File: rtl/led_matrix_driver.sv
// led_matrix_driver: 4x4 LED matrix row scanner with double-buffered frame, per-slot blanking and PWM brightness
module led_matrix_driver #(
    parameter int CLK_DIV      = 27000,
    parameter int BLANK_CYCLES = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] frame_in,
    input  logic        frame_load,
    input  logic [3:0]  brightness_in,
    output logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic        frame_pending,
    output logic        frame_start
);
    localparam int TICK = (CLK_DIV - BLANK_CYCLES) / 16;
    localparam int CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BL   = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] FULL = CW'(16 * TICK);
    localparam logic [CW-1:0] TK   = CW'(TICK);

    typedef enum logic [1:0] {BLANK, ON, OFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    row_cnt_q, row_cnt_d;
    logic [15:0]   active_frame_q, active_frame_d;
    logic [15:0]   shadow_frame_q, shadow_frame_d;
    logic [3:0]    active_bright_q, active_bright_d;
    logic [3:0]    shadow_bright_q, shadow_bright_d;
    logic          pending_q, pending_d;
    logic [3:0]    rows_q, rows_d;
    logic [3:0]    cols_q, cols_d;
    logic          frame_start_q, frame_start_d;
    logic          boundary;
    logic [CW-1:0] on_len;

    // Next-state: slot/row counters, slot FSM, shadow/active frame handover and registered drive outputs
    always_comb begin
        boundary        = (slot_cnt_q == LAST) && (row_cnt_q == 2'd3);
        on_len          = (active_bright_q == 4'd15) ? FULL : CW'(active_bright_q) * TK;
        slot_cnt_d      = (slot_cnt_q == LAST) ? '0 : slot_cnt_q + CW'(1);
        row_cnt_d       = (slot_cnt_q == LAST) ? row_cnt_q + 2'd1 : row_cnt_q;
        state_d         = (slot_cnt_d < BL) ? BLANK : ((slot_cnt_d - BL) < on_len) ? ON : OFF;
        shadow_frame_d  = frame_load ? frame_in : shadow_frame_q;
        shadow_bright_d = frame_load ? brightness_in : shadow_bright_q;
        active_frame_d  = !boundary ? active_frame_q : frame_load ? frame_in :
                          pending_q ? shadow_frame_q : active_frame_q;
        active_bright_d = !boundary ? active_bright_q : frame_load ? brightness_in :
                          pending_q ? shadow_bright_q : active_bright_q;
        pending_d       = boundary ? 1'b0 : (frame_load | pending_q);
        rows_d          = (state_q == ON) ? ~(4'b0001 << row_cnt_q) : 4'b1111;
        cols_d          = (state_q == ON) ? active_frame_q[{row_cnt_q, 2'b00} +: 4] : 4'b0000;
        frame_start_d   = boundary;
    end

    // State and output registers; reset darkens the matrix immediately and drops all frame data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= BLANK;
            slot_cnt_q      <= '0;
            row_cnt_q       <= '0;
            active_frame_q  <= '0;
            shadow_frame_q  <= '0;
            active_bright_q <= '0;
            shadow_bright_q <= '0;
            pending_q       <= 1'b0;
            rows_q          <= 4'b1111;
            cols_q          <= 4'b0000;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_cnt_q      <= slot_cnt_d;
            row_cnt_q       <= row_cnt_d;
            active_frame_q  <= active_frame_d;
            shadow_frame_q  <= shadow_frame_d;
            active_bright_q <= active_bright_d;
            shadow_bright_q <= shadow_bright_d;
            pending_q       <= pending_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign rows          = rows_q;
    assign cols          = cols_q;
    assign frame_pending = pending_q;
    assign frame_start   = frame_start_q;
endmodule

// File: tb/tb_led_matrix_driver.sv
// tb_led_matrix_driver: directed scan, load, boundary and reset checks with CLK_DIV=40, BLANK_CYCLES=8
module tb_led_matrix_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] frame_in = '0;
    logic        frame_load = 1'b0;
    logic [3:0]  brightness_in = '0;
    logic [3:0]  rows, cols;
    logic        frame_pending, frame_start;
    int          cyc;
    int          total = 0;
    int          bad = 0;

    led_matrix_driver #(.CLK_DIV(40), .BLANK_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_load(frame_load),
        .brightness_in(brightness_in), .rows(rows), .cols(cols),
        .frame_pending(frame_pending), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; equals the DUT's counter state index
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        int guard = 0;
        while (cyc < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            total++;
            bad++;
            $error("FAIL goto: got %0d want %0d", cyc, t);
        end
    endtask

    task automatic load(input logic [15:0] f, input logic [3:0] b);
        frame_in = f;
        brightness_in = b;
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
    endtask

    // Samples one full frame starting at cycle base; output at sample n reflects counter state n-1
    task automatic scan(input int base, input logic [15:0] f, input int onlen);
        int errs [4];
        int lit [4];
        int fs_cnt = 0;
        int fs_n = -1;
        goto(base);
        for (int r = 0; r < 4; r++) begin
            errs[r] = 0;
            lit[r] = 0;
        end
        for (int i = 1; i <= 160; i++) begin
            int m, s, r;
            logic on;
            logic [3:0] er, ec;
            @(negedge clk);
            m  = cyc - 1;
            s  = m % 40;
            r  = (m / 40) % 4;
            on = (s >= 8) && ((s - 8) < onlen);
            er = on ? ~(4'b0001 << r) : 4'b1111;
            ec = on ? f[4*r +: 4] : 4'b0000;
            if (rows !== er || cols !== ec) errs[r]++;
            if (rows !== 4'b1111) lit[r]++;
            if (frame_start) begin
                fs_cnt++;
                fs_n = cyc;
            end
        end
        for (int r = 0; r < 4; r++) begin
            check($sformatf("scan%0d_row%0d_pattern_errs", base, r), errs[r], 0);
            check($sformatf("scan%0d_row%0d_lit", base, r), lit[r], onlen);
        end
        check($sformatf("scan%0d_fs_count", base), fs_cnt, 1);
        check($sformatf("scan%0d_fs_at", base), fs_n, base + 160);
    endtask

    initial begin
        int litc;
        repeat (3) @(negedge clk);
        check("rst_rows", rows, 4'b1111);
        check("rst_cols", cols, 4'b0000);
        check("rst_pending", frame_pending, 1'b0);
        check("rst_fs", frame_start, 1'b0);
        reset = 1'b0;

        goto(5);
        load(16'h8421, 4'd15);
        check("load_pending", frame_pending, 1'b1);
        goto(159);
        check("pre_boundary_pending", frame_pending, 1'b1);
        check("pre_boundary_fs", frame_start, 1'b0);
        goto(160);
        check("boundary_pending", frame_pending, 1'b0);
        check("boundary_fs", frame_start, 1'b1);
        scan(160, 16'h8421, 32);

        goto(340);
        check("pre_reset_rows", rows, 4'b1110);
        #1 reset = 1'b1;
        #1;
        check("async_rst_rows", rows, 4'b1111);
        check("async_rst_cols", cols, 4'b0000);
        check("async_rst_pending", frame_pending, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        litc = 0;
        repeat (170) begin
            @(negedge clk);
            if (rows !== 4'b1111 || cols !== 4'b0000) litc++;
        end
        check("post_reset_dark", litc, 0);

        goto(175);
        load(16'hFFFF, 4'd4);
        scan(320, 16'hFFFF, 8);
        goto(485);
        load(16'hFFFF, 4'd0);
        scan(640, 16'hFFFF, 0);

        goto(805);
        load(16'h5A5A, 4'd15);
        goto(970);
        load(16'h000F, 4'd15);
        goto(1000);
        load(16'hF000, 4'd15);
        goto(1060);
        check("midframe_rows", rows, 4'b1011);
        check("midframe_cols", cols, 4'b1010);
        check("midframe_pending", frame_pending, 1'b1);
        scan(1120, 16'hF000, 32);

        goto(1439);
        check("bypass_pre_pending", frame_pending, 1'b0);
        load(16'h0F00, 4'd15);
        check("bypass_pending", frame_pending, 1'b0);
        check("bypass_fs", frame_start, 1'b1);
        scan(1440, 16'h0F00, 32);
        check("bypass_after_pending", frame_pending, 1'b0);

        scan(1600, 16'h0F00, 32);
        scan(1760, 16'h0F00, 32);
        scan(1920, 16'h0F00, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
